// File: rtl/seg_message_scroller.sv
// seg_message_scroller
// Message engine in front of the multiplexed seven-segment driver. Holds a
// small buffer of raw segment patterns and presents a NUM_DIGITS-wide window
// of it as static text, a left/right circular scroll, or a blinking static
// message. All outputs are registered; timing is derived from clk.
module seg_message_scroller #(
    parameter int NUM_DIGITS = 8,
    parameter int DEPTH      = 16,
    parameter int SCROLL_DIV = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [6:0]                  wr_data,
    input  logic [$clog2(DEPTH):0]      msg_len,
    input  logic [1:0]                  mode,
    input  logic                        enable,
    output logic [NUM_DIGITS-1:0]       AN_In,
    output logic [7*NUM_DIGITS-1:0]     C_In,
    output logic                        wrap
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int SCW = $clog2(SCROLL_DIV);
    localparam int BCW = $clog2(BLINK_DIV);
    // Wide enough to hold offset + position before the modulo reduction.
    localparam int IW  = $clog2(DEPTH + NUM_DIGITS) + 1;

    localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_DIV - 1);
    localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Registered state
    logic [6:0]     msg_buf [DEPTH];
    logic [AW-1:0]  offset;
    logic [SCW-1:0] scroll_cnt;
    logic [BCW-1:0] blink_cnt;
    logic           visible;
    mode_t          mode_q;
    logic           mode_valid;

    // Next-state values
    logic [AW-1:0]  offset_d;
    logic [SCW-1:0] scroll_cnt_d;
    logic [BCW-1:0] blink_cnt_d;
    logic           visible_d;
    logic           wrap_d;
    logic           step;

    // Window values
    logic [NUM_DIGITS-1:0]   an_d;
    logic [7*NUM_DIGITS-1:0] c_d;
    logic [IW-1:0]           idx;
    logic [6:0]              pat;

    mode_t         cur_mode;
    logic [LW-1:0] eff_len;
    logic          is_scroll;
    logic          mode_changed;

    assign cur_mode  = mode_t'(mode);
    assign eff_len   = (msg_len > LW'(DEPTH)) ? LW'(DEPTH) : msg_len;
    assign is_scroll = (cur_mode == MODE_LEFT) || (cur_mode == MODE_RIGHT);
    // mode_valid suppresses a spurious "change" on the first edge after reset.
    assign mode_changed = mode_valid && (cur_mode != mode_q);

    // Message buffer: plain registers, written one entry per cycle.
    // NOTE: the buffer is a flop array, not a RAM, so it can and must be
    // cleared by reset; a RAM-inferred memory would carry no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) msg_buf[i] <= '0;
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    // Next-state for timers, scroll offset, blink phase and the wrap pulse.
    // NOTE: every variable gets its default before any branch so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        offset_d     = offset;
        scroll_cnt_d = scroll_cnt;
        blink_cnt_d  = blink_cnt;
        visible_d    = visible;
        wrap_d       = 1'b0;
        step         = 1'b0;

        if (mode_changed) begin
            // A mode change restarts everything and beats any pending step.
            offset_d     = '0;
            scroll_cnt_d = '0;
            blink_cnt_d  = '0;
            visible_d    = 1'b1;
        end else begin
            if (enable) begin
                if (is_scroll) begin
                    if (scroll_cnt == SCROLL_LAST) begin
                        scroll_cnt_d = '0;
                        step         = 1'b1;
                    end else begin
                        scroll_cnt_d = scroll_cnt + 1'b1;
                    end
                end else begin
                    scroll_cnt_d = '0;
                end

                if (cur_mode == MODE_BLINK) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        visible_d   = ~visible;
                    end else begin
                        blink_cnt_d = blink_cnt + 1'b1;
                    end
                end else begin
                    blink_cnt_d = '0;
                    visible_d   = 1'b1;
                end
            end

            if (!is_scroll || (eff_len == '0)) begin
                offset_d = '0;
            end else if (LW'(offset) >= eff_len) begin
                // Message shrank under the current offset: restart silently.
                offset_d = '0;
            end else if (step) begin
                if (cur_mode == MODE_LEFT) begin
                    if (LW'(offset) == eff_len - 1'b1) begin
                        offset_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset + 1'b1;
                    end
                end else begin
                    if (offset == '0) begin
                        offset_d = AW'(eff_len - 1'b1);
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset - 1'b1;
                    end
                end
            end
        end
    end

    // Window build: pick the character for each position from the next
    // offset/phase so a step or toggle appears on the edge it happens.
    always_comb begin
        an_d = '0;
        c_d  = '0;
        idx  = '0;
        pat  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (is_scroll) begin
                idx = IW'(offset_d) + IW'(k);
                // Circular index by repeated conditional subtract.
                for (int i = 0; i < DEPTH + NUM_DIGITS; i++) begin
                    if ((eff_len != '0) && (idx >= IW'(eff_len))) idx = idx - IW'(eff_len);
                end
                pat = (eff_len == '0) ? 7'h00 : msg_buf[idx[AW-1:0]];
            end else begin
                idx = IW'(k);
                pat = (idx < IW'(eff_len)) ? msg_buf[idx[AW-1:0]] : 7'h00;
            end
            c_d[7*(NUM_DIGITS-1-k) +: 7] = pat;
            an_d[NUM_DIGITS-1-k]         = (pat != 7'h00) && visible_d;
        end
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset     <= '0;
            scroll_cnt <= '0;
            blink_cnt  <= '0;
            visible    <= 1'b1;
            mode_q     <= MODE_STATIC;
            mode_valid <= 1'b0;
            AN_In      <= '0;
            C_In       <= '0;
            wrap       <= 1'b0;
        end else begin
            offset     <= offset_d;
            scroll_cnt <= scroll_cnt_d;
            blink_cnt  <= blink_cnt_d;
            visible    <= visible_d;
            mode_q     <= cur_mode;
            mode_valid <= 1'b1;
            AN_In      <= an_d;
            C_In       <= c_d;
            wrap       <= wrap_d;
        end
    end

endmodule

// File: tb/tb_seg_message_scroller.sv
// Directed bench for seg_message_scroller with 4 digits, 8 entries,
// scroll every 4 cycles and blink half-period of 3 cycles.
module tb_seg_message_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [6:0]  wr_data;
    logic [3:0]  msg_len;
    logic [1:0]  mode;
    logic        enable;
    logic [3:0]  AN_In;
    logic [27:0] C_In;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    seg_message_scroller #(
        .NUM_DIGITS(4),
        .DEPTH(8),
        .SCROLL_DIV(4),
        .BLINK_DIV(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .msg_len(msg_len),
        .mode(mode),
        .enable(enable),
        .AN_In(AN_In),
        .C_In(C_In),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Leftmost character first.
    function automatic logic [27:0] pack(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c, input logic [6:0] d);
        return {a, b, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = 4'd0; mode = 2'b00; enable = 1'b1;
        repeat (2) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b0000, 28'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold: an=%b c=%h wrap=%b want an=0000 c=0 wrap=0", AN_In, C_In, wrap);
        end
        rst = 1'b0;
        msg_len = 4'd1;
        write_entry(3'd0, 7'h3F);
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1000, pack(7'h3F, 7'h00, 7'h00, 7'h00), 1'b0}) begin
            bad++;
            $display("FAIL reset_pre_write: an=%b c=%h wrap=%b want an=1000 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h3F, 7'h00, 7'h00, 7'h00));
        end
        mode = 2'b01;
        repeat (2) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b0}) begin
            bad++;
            $display("FAIL reset_pre_scroll: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h3F, 7'h3F, 7'h3F, 7'h3F));
        end
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({AN_In, C_In, wrap} !== {4'b0000, 28'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: an=%b c=%h wrap=%b want an=0000 c=0 wrap=0", AN_In, C_In, wrap);
        end
        tick();
        rst = 1'b0; mode = 2'b00; msg_len = 4'd8;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b0000, 28'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_buffer_clear: an=%b c=%h wrap=%b want an=0000 c=0 wrap=0", AN_In, C_In, wrap);
        end
    endtask

    task automatic test_static();
        mode = 2'b00; msg_len = 4'd3;
        write_entry(3'd0, 7'h06);
        write_entry(3'd1, 7'h37);
        write_entry(3'd2, 7'h73);
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1100, pack(7'h06, 7'h37, 7'h00, 7'h00), 1'b0}) begin
            bad++;
            $display("FAIL static_write_latency: an=%b c=%h wrap=%b want an=1100 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h06, 7'h37, 7'h00, 7'h00));
        end
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1110, pack(7'h06, 7'h37, 7'h73, 7'h00), 1'b0}) begin
            bad++;
            $display("FAIL static_visible: an=%b c=%h wrap=%b want an=1110 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h06, 7'h37, 7'h73, 7'h00));
        end
    endtask

    task automatic test_scroll_left();
        logic [27:0] exp_tab [6];
        exp_tab[0] = pack(7'h01, 7'h02, 7'h03, 7'h04);
        exp_tab[1] = pack(7'h02, 7'h03, 7'h04, 7'h05);
        exp_tab[2] = pack(7'h03, 7'h04, 7'h05, 7'h01);
        exp_tab[3] = pack(7'h04, 7'h05, 7'h01, 7'h02);
        exp_tab[4] = pack(7'h05, 7'h01, 7'h02, 7'h03);
        exp_tab[5] = pack(7'h01, 7'h02, 7'h03, 7'h04);
        mode = 2'b00; msg_len = 4'd5;
        for (int i = 0; i < 5; i++) write_entry(3'(i), 7'(i + 1));
        mode = 2'b01;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, exp_tab[0], 1'b0}) begin
            bad++;
            $display("FAIL scroll_left_start: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, exp_tab[0]);
        end
        for (int s = 1; s <= 5; s++) begin
            for (int h = 0; h < 3; h++) begin
                tick();
                total++;
                if ({AN_In, C_In, wrap} !== {4'b1111, exp_tab[s-1], 1'b0}) begin
                    bad++;
                    $display("FAIL scroll_left_hold[%0d]: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                             s, AN_In, C_In, wrap, exp_tab[s-1]);
                end
            end
            tick();
            total++;
            if ({AN_In, C_In, wrap} !== {4'b1111, exp_tab[s], (s == 5)}) begin
                bad++;
                $display("FAIL scroll_left_step[%0d]: an=%b c=%h wrap=%b want an=1111 c=%h wrap=%b",
                         s, AN_In, C_In, wrap, exp_tab[s], (s == 5));
            end
        end
        tick();
        total++;
        if (wrap !== 1'b0) begin
            bad++;
            $display("FAIL scroll_left_wrap_once: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_scroll_right();
        mode = 2'b10;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h01, 7'h02, 7'h03, 7'h04), 1'b0}) begin
            bad++;
            $display("FAIL scroll_right_start: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h01, 7'h02, 7'h03, 7'h04));
        end
        repeat (4) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h05, 7'h01, 7'h02, 7'h03), 1'b1}) begin
            bad++;
            $display("FAIL scroll_right_first_step: an=%b c=%h wrap=%b want an=1111 c=%h wrap=1",
                     AN_In, C_In, wrap, pack(7'h05, 7'h01, 7'h02, 7'h03));
        end
        repeat (4) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h04, 7'h05, 7'h01, 7'h02), 1'b0}) begin
            bad++;
            $display("FAIL scroll_right_second_step: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h04, 7'h05, 7'h01, 7'h02));
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_an [5];
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1110; exp_an[2] = 4'b1110;
        exp_an[3] = 4'b0000; exp_an[4] = 4'b0000;
        mode = 2'b11; msg_len = 4'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({AN_In, C_In, wrap} !== {exp_an[i], pack(7'h01, 7'h02, 7'h03, 7'h00), 1'b0}) begin
                bad++;
                $display("FAIL blink_phase[%0d]: an=%b c=%h wrap=%b want an=%b c=%h wrap=0",
                         i, AN_In, C_In, wrap, exp_an[i], pack(7'h01, 7'h02, 7'h03, 7'h00));
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({AN_In, C_In} !== {4'b0000, pack(7'h01, 7'h02, 7'h03, 7'h00)}) begin
                bad++;
                $display("FAIL blink_frozen[%0d]: an=%b c=%h want an=0000 c=%h",
                         i, AN_In, C_In, pack(7'h01, 7'h02, 7'h03, 7'h00));
            end
        end
        enable = 1'b1;
        tick();
        total++;
        if (AN_In !== 4'b0000) begin
            bad++;
            $display("FAIL blink_resume_dark: an=%b want 0000", AN_In);
        end
        tick();
        total++;
        if (AN_In !== 4'b1110) begin
            bad++;
            $display("FAIL blink_resume_lit: an=%b want 1110", AN_In);
        end
    endtask

    task automatic test_boundaries();
        mode = 2'b01; msg_len = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({AN_In, C_In, wrap} !== {4'b0000, 28'h0, 1'b0}) begin
                bad++;
                $display("FAIL len_zero[%0d]: an=%b c=%h wrap=%b want an=0000 c=0 wrap=0",
                         i, AN_In, C_In, wrap);
            end
        end
        write_entry(3'd5, 7'h06);
        write_entry(3'd6, 7'h07);
        write_entry(3'd7, 7'h08);
        msg_len = 4'd8; mode = 2'b00;
        tick();
        mode = 2'b01;
        tick();
        repeat (24) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h07, 7'h08, 7'h01, 7'h02), 1'b0}) begin
            bad++;
            $display("FAIL len8_offset6: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h07, 7'h08, 7'h01, 7'h02));
        end
        msg_len = 4'd4;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h01, 7'h02, 7'h03, 7'h04), 1'b0}) begin
            bad++;
            $display("FAIL len_shrink: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h01, 7'h02, 7'h03, 7'h04));
        end
        repeat (3) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h02, 7'h03, 7'h04, 7'h01), 1'b0}) begin
            bad++;
            $display("FAIL len_shrink_step: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h02, 7'h03, 7'h04, 7'h01));
        end
        msg_len = 4'd9; mode = 2'b10;
        repeat (5) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h08, 7'h01, 7'h02, 7'h03), 1'b1}) begin
            bad++;
            $display("FAIL len_clamp: an=%b c=%h wrap=%b want an=1111 c=%h wrap=1",
                     AN_In, C_In, wrap, pack(7'h08, 7'h01, 7'h02, 7'h03));
        end
    endtask

    task automatic test_collisions();
        mode = 2'b01; msg_len = 4'd5;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h01, 7'h02, 7'h03, 7'h04), 1'b0}) begin
            bad++;
            $display("FAIL collide_start: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h01, 7'h02, 7'h03, 7'h04));
        end
        repeat (3) tick();
        write_entry(3'd1, 7'h7F);
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h02, 7'h03, 7'h04, 7'h05), 1'b0}) begin
            bad++;
            $display("FAIL collide_step_old_data: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h02, 7'h03, 7'h04, 7'h05));
        end
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h7F, 7'h03, 7'h04, 7'h05), 1'b0}) begin
            bad++;
            $display("FAIL collide_write_new_data: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h7F, 7'h03, 7'h04, 7'h05));
        end
        repeat (2) tick();
        mode = 2'b10;
        tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h01, 7'h7F, 7'h03, 7'h04), 1'b0}) begin
            bad++;
            $display("FAIL collide_mode_wins: an=%b c=%h wrap=%b want an=1111 c=%h wrap=0",
                     AN_In, C_In, wrap, pack(7'h01, 7'h7F, 7'h03, 7'h04));
        end
        repeat (4) tick();
        total++;
        if ({AN_In, C_In, wrap} !== {4'b1111, pack(7'h05, 7'h01, 7'h7F, 7'h03), 1'b1}) begin
            bad++;
            $display("FAIL collide_mode_restart: an=%b c=%h wrap=%b want an=1111 c=%h wrap=1",
                     AN_In, C_In, wrap, pack(7'h05, 7'h01, 7'h7F, 7'h03));
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll_left();
        test_scroll_right();
        test_blink();
        test_boundaries();
        test_collisions();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_message_scroller.md
# seg_message_scroller

Parametrised message engine that feeds the multiplexed seven-segment driver with its per-digit enable mask and packed segment bus. Software or a game FSM writes raw segment patterns into a message buffer. The block then shows them static, scrolled left or right, or blinking, with all timing derived from `clk`. It replaces hard-coded banner logic in front of the display driver.

## Interface
- `NUM_DIGITS`, 8, number of physical digits driven.
- `DEPTH`, 16, message buffer entries; power of 2, ≥ 2.
- `SCROLL_DIV`, 50_000_000, clk cycles per scroll step; ≥ 2.
- `BLINK_DIV`, 25_000_000, clk cycles per blink half-period; ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(DEPTH)  buffer entry to write.
- `wr_data`  in  7  segment pattern {g,f,e,d,c,b,a}, active-high.
- `msg_len`  in  $clog2(DEPTH)+1  active message length.
- `mode`  in  2  display mode:
  - 00 static
  - 01 scroll left
  - 10 scroll right
  - 11 blink (static + blink)
- `enable`  in  1  1 = timers run; 0 = timers and offset frozen.
- `AN_In`  out  NUM_DIGITS  digit enable, 1 = lit; bit NUM_DIGITS-1 = leftmost digit.
- `C_In`  out  7*NUM_DIGITS  packed patterns; leftmost digit in the top 7 bits.
- `wrap`  out  1  one-cycle pulse when the scroll offset wraps.

## Operation
- **Buffer:** DEPTH x 7 registers, cleared by reset. A write at edge N is visible on outputs at edge N+1.
- **Effective length:** L = min(`msg_len`, DEPTH). L = 0 means all digits blank: `AN_In`=0, `C_In`=0.
- **Window:** position k = 0..NUM_DIGITS-1 from the left drives digit NUM_DIGITS-1-k.
  - Static/blink: char index = k. Positions with k ≥ L are blank (pattern 0).
  - Scroll modes: char index = (offset + k) mod L, circular, so short messages repeat. Mod is computed by repeated conditional subtract; no divider.
- **Anode rule:** `AN_In[d]` = (pattern ≠ 0) & visible. A zero pattern always leaves its digit dark.
- **Scroll step:** when the scroll counter reaches SCROLL_DIV-1 it returns to 0 and the offset steps.
  - Left: offset+1, wrapping L-1 → 0 with `wrap`=1 that cycle.
  - Right: offset-1, wrapping 0 → L-1 with `wrap`=1.
  - Static/blink: the counter holds at 0 and offset = 0.
- **Blink:** the blink counter divides by BLINK_DIV and toggles `visible` on each terminal count.
  - When `visible`=0, `AN_In` is all 0 while `C_In` still carries the patterns.
  - In non-blink modes `visible` is held at 1.
- **Mode change:** any change of `mode` clears offset, both counters, and sets `visible`=1 on the next edge. No step or `wrap` occurs on that edge.
- **Length shrink:** if L changes and offset ≥ new L, offset is forced to 0 on the next edge with no `wrap` pulse.
- **Enable low:** counters, offset and `visible` hold. Outputs still track buffer contents.
- **Simultaneous events:**
  - Write and step on the same edge: both take effect; outputs at N+1 use the new offset and new data.
  - Mode change and step on the same edge: the mode change wins.

## Timing
- Reset values:
  - `AN_In`=0, `C_In`=0, `wrap`=0.
  - offset=0, both counters 0, `visible`=1, buffer all 0.
- All outputs are registered. Latency from any input change to the outputs is 1 cycle.
- The first scroll step after reset or a mode change lands at edge SCROLL_DIV. Subsequent steps are every SCROLL_DIV cycles while `enable`=1.
- `wrap` is high for exactly one cycle, coincident with the output update that shows offset 0 (left) or L-1 (right).
- Reset asserted mid-operation clears all state immediately, including the buffer. Release is synchronous to the next `clk` edge.

## Test plan
All scenarios use NUM_DIGITS=4, DEPTH=8, SCROLL_DIV=4, BLINK_DIV=3.

1. **Reset:** assert `rst` mid-scroll → `AN_In`=0000, `C_In`=0, `wrap`=0 immediately. Buffer reads back 0 after release.
2. **Static:** write entries 0..2 = 0x06, 0x37, 0x73, set L=3, mode 00 → `C_In`={06,37,73,00}, `AN_In`=1110 one cycle after the last write.
3. **Scroll left:** L=5, entries 0..4 = 01..05, mode 01.
   - Offset steps every 4 cycles.
   - After 5 steps the display returns to {01,02,03,04} and `wrap` pulses once.
   - Right-scroll mirror: the first step shows {05,01,02,03} with `wrap`=1.
4. **Blink:** mode 11 → `AN_In` alternates 1110/0000 every 3 cycles while `C_In` stays constant. Deasserting `enable` freezes the phase.
5. **Boundaries:**
   - L=0 → all outputs 0.
   - L=8 with offset 6, then L lowered to 4 → offset 0 next edge, no `wrap`.
   - `msg_len`=9 behaves as L=8.
6. **Collisions:** a write to the leftmost displayed entry on the step edge shows new data at the new offset next cycle. A mode change on a step edge gives offset=0 and no `wrap`.
